// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order retirement of out-of-order results, with operand
// bypass queries, store retirement signalling and branch-mispredict rollback.
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int POS_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,

  input  logic             issue,
  input  logic [1:0]       issue_type,
  input  logic [4:0]       issue_rd,
  input  logic             issue_pred_jump,
  input  logic [31:0]      issue_pc,
  output logic             full,
  output logic [POS_W-1:0] tail_pos,

  input  logic             alu_wb,
  input  logic [POS_W-1:0] alu_pos,
  input  logic [31:0]      alu_val,
  input  logic             alu_jump,
  input  logic [31:0]      alu_target,
  input  logic             lsb_wb,
  input  logic [POS_W-1:0] lsb_pos,
  input  logic [31:0]      lsb_val,

  input  logic [POS_W-1:0] q1_pos,
  input  logic [POS_W-1:0] q2_pos,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [31:0]      q1_val,
  output logic [31:0]      q2_val,

  output logic             commit,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_val,
  output logic [POS_W-1:0] commit_rob_pos,
  output logic             store_commit,

  output logic             rollback,
  output logic [31:0]      rollback_pc
);

  localparam logic [1:0]       TYPE_REG    = 2'd0;
  localparam logic [1:0]       TYPE_BRANCH = 2'd1;
  localparam logic [1:0]       TYPE_STORE  = 2'd2;
  localparam int               CNT_W       = POS_W + 1;
  localparam logic [POS_W-1:0] POS_ZERO    = {POS_W{1'b0}};
  localparam logic [POS_W-1:0] POS_ONE     = {{(POS_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{POS_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(ROB_SIZE);

  // Entry storage
  logic [ROB_SIZE-1:0] busy_r;
  logic [ROB_SIZE-1:0] ready_r;
  logic [ROB_SIZE-1:0] pred_jump_r;
  logic [ROB_SIZE-1:0] real_jump_r;
  logic [1:0]          type_r   [ROB_SIZE];
  logic [4:0]          rd_r     [ROB_SIZE];
  logic [31:0]         val_r    [ROB_SIZE];
  logic [31:0]         target_r [ROB_SIZE];

  logic [POS_W-1:0]    head_r;
  logic [POS_W-1:0]    tail_r;
  logic [CNT_W-1:0]    count_r;

  logic                commit_r;
  logic [4:0]          commit_rd_r;
  logic [31:0]         commit_val_r;
  logic [POS_W-1:0]    commit_rob_pos_r;
  logic                store_commit_r;
  logic                rollback_r;
  logic [31:0]         rollback_pc_r;

  logic                full_s;
  logic                do_commit_s;
  logic                mispredict_s;
  logic                do_issue_s;
  logic                do_alu_s;
  logic                do_lsb_s;
  logic [4:0]          commit_rd_s;
  logic [CNT_W-1:0]    count_nxt_s;

  assign full_s         = (count_r == CNT_FULL);
  assign full           = full_s;
  assign tail_pos       = tail_r;
  assign commit         = commit_r;
  assign commit_rd      = commit_rd_r;
  assign commit_val     = commit_val_r;
  assign commit_rob_pos = commit_rob_pos_r;
  assign store_commit   = store_commit_r;
  assign rollback       = rollback_r;
  assign rollback_pc    = rollback_pc_r;

  // Per-cycle decisions, all taken from pre-update state (full is pre-commit)
  always_comb begin
    do_commit_s  = busy_r[head_r] & ready_r[head_r] & ~rollback_r;
    mispredict_s = do_commit_s & (type_r[head_r] == TYPE_BRANCH) &
                   (pred_jump_r[head_r] != real_jump_r[head_r]);
    do_issue_s   = issue & ~full_s & ~rollback_r;
    do_alu_s     = alu_wb & busy_r[alu_pos] & ~rollback_r;
    do_lsb_s     = lsb_wb & busy_r[lsb_pos] & ~rollback_r &
                   ~(alu_wb & (alu_pos == lsb_pos));
    if (type_r[head_r] == TYPE_STORE) begin
      commit_rd_s = 5'd0;
    end else begin
      commit_rd_s = rd_r[head_r];
    end
    case ({do_issue_s, do_commit_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Operand queries: stored result first, then same-cycle ALU, then LSB bypass
  always_comb begin
    q1_ready = 1'b0;
    q1_val   = 32'd0;
    q2_ready = 1'b0;
    q2_val   = 32'd0;
    if (ready_r[q1_pos]) begin
      q1_ready = 1'b1;
      q1_val   = val_r[q1_pos];
    end else if (alu_wb && (alu_pos == q1_pos)) begin
      q1_ready = 1'b1;
      q1_val   = alu_val;
    end else if (lsb_wb && (lsb_pos == q1_pos)) begin
      q1_ready = 1'b1;
      q1_val   = lsb_val;
    end else begin
      q1_ready = 1'b0;
      q1_val   = 32'd0;
    end
    if (ready_r[q2_pos]) begin
      q2_ready = 1'b1;
      q2_val   = val_r[q2_pos];
    end else if (alu_wb && (alu_pos == q2_pos)) begin
      q2_ready = 1'b1;
      q2_val   = alu_val;
    end else if (lsb_wb && (lsb_pos == q2_pos)) begin
      q2_ready = 1'b1;
      q2_val   = lsb_val;
    end else begin
      q2_ready = 1'b0;
      q2_val   = 32'd0;
    end
  end

  // Entry array update; the commit clear is last so it overrides a same-slot writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r      <= {ROB_SIZE{1'b0}};
      ready_r     <= {ROB_SIZE{1'b0}};
      pred_jump_r <= {ROB_SIZE{1'b0}};
      real_jump_r <= {ROB_SIZE{1'b0}};
      for (int i = 0; i < ROB_SIZE; i++) begin
        type_r[i]   <= TYPE_REG;
        rd_r[i]     <= 5'd0;
        val_r[i]    <= 32'd0;
        target_r[i] <= 32'd0;
      end
    end else if (rdy) begin
      if (mispredict_s) begin
        busy_r  <= {ROB_SIZE{1'b0}};
        ready_r <= {ROB_SIZE{1'b0}};
      end else begin
        if (do_alu_s) begin
          ready_r[alu_pos]     <= 1'b1;
          val_r[alu_pos]       <= alu_val;
          real_jump_r[alu_pos] <= alu_jump;
          target_r[alu_pos]    <= alu_target;
        end
        if (do_lsb_s) begin
          ready_r[lsb_pos] <= 1'b1;
          val_r[lsb_pos]   <= lsb_val;
        end
        if (do_issue_s) begin
          busy_r[tail_r]      <= 1'b1;
          ready_r[tail_r]     <= (issue_type == TYPE_STORE);
          type_r[tail_r]      <= issue_type;
          rd_r[tail_r]        <= issue_rd;
          val_r[tail_r]       <= 32'd0;
          pred_jump_r[tail_r] <= issue_pred_jump;
          real_jump_r[tail_r] <= 1'b0;
          target_r[tail_r]    <= issue_pc + 32'd4;
        end
        if (do_commit_s) begin
          busy_r[head_r]  <= 1'b0;
          ready_r[head_r] <= 1'b0;
        end
      end
    end
  end

  // Pointers, occupancy and the registered commit/rollback outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r           <= POS_ZERO;
      tail_r           <= POS_ZERO;
      count_r          <= CNT_ZERO;
      commit_r         <= 1'b0;
      commit_rd_r      <= 5'd0;
      commit_val_r     <= 32'd0;
      commit_rob_pos_r <= POS_ZERO;
      store_commit_r   <= 1'b0;
      rollback_r       <= 1'b0;
      rollback_pc_r    <= 32'd0;
    end else if (rdy) begin
      commit_r       <= do_commit_s;
      store_commit_r <= do_commit_s & (type_r[head_r] == TYPE_STORE);
      rollback_r     <= mispredict_s;
      if (do_commit_s) begin
        commit_rd_r      <= commit_rd_s;
        commit_val_r     <= val_r[head_r];
        commit_rob_pos_r <= head_r;
      end
      if (mispredict_s) begin
        rollback_pc_r <= target_r[head_r];
        head_r        <= POS_ZERO;
        tail_r        <= POS_ZERO;
        count_r       <= CNT_ZERO;
      end else begin
        if (do_commit_s) begin
          head_r <= head_r + POS_ONE;
        end
        if (do_issue_s) begin
          tail_r <= tail_r + POS_ONE;
        end
        count_r <= count_nxt_s;
      end
    end
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_SIZE, default 16: number of entries, power of two.
REQ-002 SHALL have parameter POS_W, default 4: entry index width, log2(ROB_SIZE).
REQ-003 SHALL have port clk, input, 1: clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port rdy, input, 1: global enable; when low, all state and registered outputs hold.
REQ-006 SHALL have issue ports: issue (in, 1), issue_type (in, 2; 0=REG, 1=BRANCH, 2=STORE), issue_rd (in, 5), issue_pred_jump (in, 1), issue_pc (in, 32).
REQ-007 SHALL have ports full (out, 1) and tail_pos (out, POS_W), both combinational: the index the next issued instruction receives.
REQ-008 SHALL have writeback ports alu_wb (in, 1), alu_pos (in, POS_W), alu_val (in, 32), alu_jump (in, 1), alu_target (in, 32), lsb_wb (in, 1), lsb_pos (in, POS_W), lsb_val (in, 32).
REQ-009 SHALL have query ports q1_pos, q2_pos (in, POS_W) and q1_ready, q2_ready (out, 1), q1_val, q2_val (out, 32), combinational.
REQ-010 SHALL have registered commit ports commit (out, 1), commit_rd (out, 5), commit_val (out, 32), commit_rob_pos (out, POS_W), store_commit (out, 1).
REQ-011 SHALL have registered ports rollback (out, 1) and rollback_pc (out, 32).

Function
REQ-012 Each entry SHALL hold busy, ready, type, rd, val, pred_jump, real_jump, target.
REQ-013 head and tail pointers SHALL be POS_W bits and wrap from ROB_SIZE-1 to 0; count SHALL be POS_W+1 bits.
REQ-014 full SHALL equal (count == ROB_SIZE); tail_pos SHALL equal tail.
REQ-015 On issue && !full && !rollback: entry[tail] gets busy=1, ready=(type==STORE), rd, pred_jump, target=issue_pc+4; tail increments.
REQ-016 issue while full or while rollback is high SHALL be ignored with no state change.
REQ-017 alu_wb SHALL set entry[alu_pos] ready=1, val=alu_val, real_jump=alu_jump, target=alu_target only if entry is busy; lsb_wb SHALL set ready=1, val=lsb_val likewise.
REQ-018 Writebacks to non-busy entries, or while rollback is high, SHALL be ignored.
REQ-019 Query qN SHALL return ready=1 and the value if entry[qN_pos] is ready, else bypass a same-cycle alu_wb/lsb_wb to that position (ALU takes priority), else ready=0, val=0.
REQ-020 Commit SHALL occur in a cycle iff entry[head] busy && ready && !rollback; at most one commit per cycle.
REQ-021 On commit, next cycle: commit=1, commit_rd=rd (0 for STORE/BRANCH without link), commit_val=val, commit_rob_pos=head; store_commit=1 iff type==STORE; entry cleared, head increments.
REQ-022 In cycles with no commit, commit and store_commit SHALL be 0 next cycle.
REQ-023 Committed BRANCH with pred_jump != real_jump SHALL register rollback=1 and rollback_pc=target for exactly one cycle.
REQ-024 On a mispredict commit, all entries SHALL clear busy/ready and head, tail, and count SHALL become 0 next cycle; a same-cycle issue SHALL be discarded.
REQ-025 Simultaneous issue and commit SHALL leave count unchanged; issue into a slot freed in the same cycle SHALL not occur (full is evaluated pre-commit).
REQ-026 Simultaneous alu_wb and lsb_wb to the same position is illegal; ALU SHALL win.

Reset
REQ-027 On rst: all entries cleared, head=tail=count=0, commit=0, commit_rd=0, commit_val=0, commit_rob_pos=0, store_commit=0, rollback=0, rollback_pc=0.
REQ-028 rst SHALL take priority over rdy and all other inputs, including mid-rollback or mid-commit.
REQ-029 After reset: full=0, tail_pos=0, q1_ready=q2_ready=0.

Verification
REQ-030 Issue REG rd=5 at pos 0, alu_wb pos 0 val=0x1234 -> next cycle ready; following cycle commit=1, rd=5, val=0x1234, rob_pos=0.
REQ-031 Issue 16 instructions without writeback -> full=1; 17th issue ignored, tail_pos=0; commit one -> full=0 the cycle after commit.
REQ-032 Issue pos 0 and pos 1; writeback pos 1 first, then pos 0 -> commits appear in order 0 then 1 on consecutive cycles.
REQ-033 Issue BRANCH pred_jump=0, alu_wb alu_jump=1, alu_target=0x100 -> rollback=1, rollback_pc=0x100 for one cycle; afterwards count=0, tail_pos=0, and younger entries never commit.
REQ-034 Issue STORE -> commits without writeback with store_commit=1, commit_rd=0.
REQ-035 Query q1_pos=3 in the same cycle as alu_wb pos 3 val=0xAA -> q1_ready=1, q1_val=0xAA; rdy=0 for 3 cycles mid-stream -> no commit and no pointer movement.
